// File: rtl/md_pkg.sv
// Shared definitions for the motion-update broadcast path: the FSM state
// encoding, the default fixed-point coordinate geometry, and the cell-ID
// pack/unpack helpers.
package md_pkg;

  localparam int COORD_WIDTH = 32;
  localparam int CELL_W      = 4;
  localparam int FRAC_WIDTH  = COORD_WIDTH - CELL_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_EN_ON,
    S_RD_NUM,
    S_WAIT_NUM,
    S_STREAM,
    S_DRAIN,
    S_NEXT_CELL,
    S_FLUSH,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [CELL_W-1:0] x;
    logic [CELL_W-1:0] y;
    logic [CELL_W-1:0] z;
  } cell_id_t;

  function automatic logic [3*CELL_W-1:0] pack_cell(input logic [CELL_W-1:0] x,
                                                    input logic [CELL_W-1:0] y,
                                                    input logic [CELL_W-1:0] z);
    return {x, y, z};
  endfunction

  function automatic cell_id_t unpack_cell(input logic [3*CELL_W-1:0] id);
    return cell_id_t'(id);
  endfunction

endpackage

// File: rtl/pos_wrap_cell_calc.sv
// One axis of the position update: adds a signed displacement to an
// unsigned fixed-point coordinate, wraps it periodically into
// [0, NUM_CELL) cells and reports the 1-based destination cell index.
// Purely combinational; the caller registers the results.
module pos_wrap_cell_calc
  import md_pkg::*;
#(
  parameter int COORD_W  = COORD_WIDTH,
  parameter int FRAC_W   = FRAC_WIDTH,
  parameter int NUM_CELL = 3
) (
  input  logic [COORD_W-1:0]        pos_i,
  input  logic [COORD_W-1:0]        disp_i,
  output logic [COORD_W-1:0]        wrapped_o,
  output logic [COORD_W-FRAC_W-1:0] cell_o
);

  localparam int CIW = COORD_W - FRAC_W;

  // Box length in fixed point; only the low COORD_W bits are needed since
  // the wrap result is always back inside the box.
  localparam logic [COORD_W-1:0] SPAN = {CIW'(NUM_CELL), {FRAC_W{1'b0}}};

  logic signed [COORD_W:0] sum;
  logic [COORD_W-1:0]      wrapped;

  assign sum = $signed({1'b0, pos_i}) + $signed({disp_i[COORD_W-1], disp_i});

  // Periodic wrap: a displacement is below one cell, so one correction suffices.
  always_comb begin
    wrapped = sum[COORD_W-1:0];
    if (sum[COORD_W]) begin
      wrapped = sum[COORD_W-1:0] + SPAN;
    end else if (sum[COORD_W-1:FRAC_W] >= CIW'(NUM_CELL)) begin
      wrapped = sum[COORD_W-1:0] - SPAN;
    end
  end

  assign wrapped_o = wrapped;
  assign cell_o    = wrapped[COORD_W-1:FRAC_W] + CIW'(1);

endmodule

// File: rtl/motion_update_broadcaster.sv
// Source end of the motion-update broadcast bus. Walks every cell cache in
// x/y/z order, reads the particle count and then each particle, applies the
// displacement with periodic wrap and broadcasts the new position together
// with its destination cell. Enable is held across the whole walk so the
// double-buffered caches swap only once, after a short flush.
module motion_update_broadcaster
  import md_pkg::*;
#(
  parameter int DATA_WIDTH    = 3 * COORD_WIDTH,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = CELL_W,
  parameter int NUM_CELL_X    = 3,
  parameter int NUM_CELL_Y    = 3,
  parameter int NUM_CELL_Z    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
  output logic [ADDR_WIDTH-1:0]      out_read_address,
  output logic                       out_rden,
  input  logic [DATA_WIDTH-1:0]      in_pos_data,
  input  logic [DATA_WIDTH-1:0]      in_disp_data,
  output logic                       out_motion_update_enable,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       out_done
);

  localparam int CW  = DATA_WIDTH / 3;
  localparam int FW  = CW - CELL_ID_WIDTH;
  localparam int CIW = CELL_ID_WIDTH;
  localparam logic [CW-1:0] MAX_ADDR = CW'({ADDR_WIDTH{1'b1}});

  state_e                 state_q;
  logic [CIW-1:0]         cx_q, cy_q, cz_q;
  logic [CIW-1:0]         nx_d, ny_d, nz_d;
  logic                   last_cell_d;
  logic [3*CIW-1:0]       rd_cell_q;
  logic [ADDR_WIDTH-1:0]  addr_q, n_q, n_d;
  logic                   rden_q, en_q, done_q, drain_q;
  logic [1:0]             flush_q;
  logic                   vld_p0_q, vld_p1_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [3*CIW-1:0]       dst_q;
  logic                   valid_q;
  logic [CW-1:0]          wx, wy, wz;
  logic [CIW-1:0]         dx, dy, dz;

  // Next cell in walk order (z fastest, then y, then x) and last-cell flag.
  always_comb begin
    nx_d        = cx_q;
    ny_d        = cy_q;
    nz_d        = cz_q + CIW'(1);
    last_cell_d = (cx_q == CIW'(NUM_CELL_X)) && (cy_q == CIW'(NUM_CELL_Y)) &&
                  (cz_q == CIW'(NUM_CELL_Z));
    if (cz_q == CIW'(NUM_CELL_Z)) begin
      nz_d = CIW'(1);
      ny_d = cy_q + CIW'(1);
      if (cy_q == CIW'(NUM_CELL_Y)) begin
        ny_d = CIW'(1);
        nx_d = cx_q + CIW'(1);
      end
    end
  end

  // Particle count from the address-0 word, clamped to the addressable range.
  always_comb begin
    if (in_pos_data[CW-1:0] > MAX_ADDR) n_d = {ADDR_WIDTH{1'b1}};
    else                                n_d = in_pos_data[ADDR_WIDTH-1:0];
  end

  // Walk controller: cell pointer, read address, enable, drain/flush timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cx_q      <= CIW'(1);
      cy_q      <= CIW'(1);
      cz_q      <= CIW'(1);
      rd_cell_q <= '0;
      addr_q    <= '0;
      n_q       <= '0;
      rden_q    <= 1'b0;
      vld_p0_q  <= 1'b0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
      flush_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_EN_ON;
            en_q      <= 1'b1;
            cx_q      <= CIW'(1);
            cy_q      <= CIW'(1);
            cz_q      <= CIW'(1);
            rd_cell_q <= pack_cell(CIW'(1), CIW'(1), CIW'(1));
          end
        end
        S_EN_ON: begin
          state_q <= S_RD_NUM;
          rden_q  <= 1'b1;
          addr_q  <= '0;
        end
        S_RD_NUM: begin
          state_q <= S_WAIT_NUM;
          rden_q  <= 1'b0;
        end
        S_WAIT_NUM: begin
          n_q <= n_d;
          if (n_d == '0) begin
            state_q <= S_NEXT_CELL;
          end else begin
            state_q  <= S_STREAM;
            rden_q   <= 1'b1;
            vld_p0_q <= 1'b1;
            addr_q   <= ADDR_WIDTH'(1);
          end
        end
        S_STREAM: begin
          if (addr_q == n_q) begin
            state_q  <= S_DRAIN;
            rden_q   <= 1'b0;
            vld_p0_q <= 1'b0;
            addr_q   <= '0;
            drain_q  <= 1'b0;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (drain_q) state_q <= S_NEXT_CELL;
          drain_q <= 1'b1;
        end
        S_NEXT_CELL: begin
          if (last_cell_d) begin
            state_q <= S_FLUSH;
            en_q    <= 1'b0;
            flush_q <= '0;
          end else begin
            state_q   <= S_RD_NUM;
            cx_q      <= nx_d;
            cy_q      <= ny_d;
            cz_q      <= nz_d;
            rd_cell_q <= pack_cell(nx_d, ny_d, nz_d);
            rden_q    <= 1'b1;
            addr_q    <= '0;
          end
        end
        S_FLUSH: begin
          if (flush_q == 2'd2) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            flush_q <= flush_q + 2'd1;
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
          rd_cell_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  pos_wrap_cell_calc #(.COORD_W(CW), .FRAC_W(FW), .NUM_CELL(NUM_CELL_X)) u_calc_x (
    .pos_i(in_pos_data[CW-1:0]), .disp_i(in_disp_data[CW-1:0]),
    .wrapped_o(wx), .cell_o(dx)
  );
  pos_wrap_cell_calc #(.COORD_W(CW), .FRAC_W(FW), .NUM_CELL(NUM_CELL_Y)) u_calc_y (
    .pos_i(in_pos_data[2*CW-1:CW]), .disp_i(in_disp_data[2*CW-1:CW]),
    .wrapped_o(wy), .cell_o(dy)
  );
  pos_wrap_cell_calc #(.COORD_W(CW), .FRAC_W(FW), .NUM_CELL(NUM_CELL_Z)) u_calc_z (
    .pos_i(in_pos_data[3*CW-1:2*CW]), .disp_i(in_disp_data[3*CW-1:2*CW]),
    .wrapped_o(wz), .cell_o(dz)
  );

  // Valid pipe stage p1: particle readout is present on in_pos_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p0_q;
  end

  // Output register: broadcast word, zeroed whenever it is not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      dst_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= vld_p1_q;
      if (vld_p1_q) begin
        data_q <= {wz, wy, wx};
        dst_q  <= pack_cell(dx, dy, dz);
      end else begin
        data_q <= '0;
        dst_q  <= '0;
      end
    end
  end

  assign out_rd_cell              = rd_cell_q;
  assign out_read_address         = addr_q;
  assign out_rden                 = rden_q;
  assign out_motion_update_enable = en_q;
  assign out_data                 = data_q;
  assign out_data_dst_cell        = dst_q;
  assign out_data_valid           = valid_q;
  assign out_done                 = done_q;

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// Bench for motion_update_broadcaster: models the 18 cell caches as arrays,
// predicts every broadcast word from plain fixed-point arithmetic, and
// scoreboards the DUT output stream plus its enable/done timing.
module tb_motion_update_broadcaster;
  import md_pkg::*;

  localparam longint UNIT = 64'd1 << 28;
  localparam int NCELLS = 18;
  localparam int MAXP   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] out_rd_cell;
  logic [7:0]  out_read_address;
  logic        out_rden;
  logic [95:0] in_pos_data  = '0;
  logic [95:0] in_disp_data = '0;
  logic        out_motion_update_enable;
  logic [95:0] out_data;
  logic [11:0] out_data_dst_cell;
  logic        out_data_valid;
  logic        out_done;

  motion_update_broadcaster dut (
    .clk(clk), .rst(rst), .start(start),
    .out_rd_cell(out_rd_cell), .out_read_address(out_read_address), .out_rden(out_rden),
    .in_pos_data(in_pos_data), .in_disp_data(in_disp_data),
    .out_motion_update_enable(out_motion_update_enable),
    .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
    .out_data_valid(out_data_valid), .out_done(out_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] data;
    logic [11:0] dst;
  } exp_t;

  logic [95:0] pos_m  [0:NCELLS-1][0:MAXP-1];
  logic [95:0] disp_m [0:NCELLS-1][0:MAXP-1];
  int          cnt_m  [0:NCELLS-1];
  exp_t        exp_q[$];
  int          lat_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int visits = 0;
  int done_cnt = 0;
  int fall_cyc = 0;
  bit prev_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic longint wrap_axis(input longint p, input longint d, input int n);
    longint s, span;
    s = p + d;
    span = longint'(n) * UNIT;
    if (s < 0) s = s + span;
    else if (s >= span) s = s - span;
    return s;
  endfunction

  function automatic logic [95:0] mk(input longint x, input longint y, input longint z);
    logic [31:0] xs, ys, zs;
    xs = 32'(x); ys = 32'(y); zs = 32'(z);
    return {zs, ys, xs};
  endfunction

  // Expected broadcast stream: cells in x/y/z order, particles in cache order.
  task automatic build_expected();
    int idx;
    exp_t e;
    logic [31:0] pw, dw;
    int signed ds;
    longint w;
    int ncell[3];
    logic [3:0] dc[3];
    ncell[0] = 3; ncell[1] = 3; ncell[2] = 2;
    exp_q.delete();
    for (int x = 1; x <= 3; x++)
      for (int y = 1; y <= 3; y++)
        for (int z = 1; z <= 2; z++) begin
          idx = ((x - 1) * 3 + (y - 1)) * 2 + (z - 1);
          for (int k = 0; k < cnt_m[idx]; k++) begin
            for (int a = 0; a < 3; a++) begin
              pw = pos_m[idx][k][a*32 +: 32];
              dw = disp_m[idx][k][a*32 +: 32];
              ds = dw;
              w = wrap_axis({32'd0, pw}, longint'(ds), ncell[a]);
              e.data[a*32 +: 32] = w[31:0];
              dc[a] = 4'(w / UNIT + 1);
            end
            e.dst = {dc[0], dc[1], dc[2]};
            exp_q.push_back(e);
          end
        end
  endtask

  task automatic clear_mem();
    for (int c = 0; c < NCELLS; c++) begin
      cnt_m[c] = 0;
      for (int k = 0; k < MAXP; k++) begin
        pos_m[c][k] = '0;
        disp_m[c][k] = '0;
      end
    end
  endtask

  task automatic fill_random();
    longint p[3], d[3];
    int ncell[3];
    ncell[0] = 3; ncell[1] = 3; ncell[2] = 2;
    clear_mem();
    for (int c = 0; c < NCELLS; c++) begin
      cnt_m[c] = $urandom_range(0, 4);
      for (int k = 0; k < cnt_m[c]; k++) begin
        for (int a = 0; a < 3; a++) begin
          p[a] = longint'($urandom_range(0, 32'(longint'(ncell[a]) * UNIT - 1)));
          d[a] = longint'($urandom_range(0, 32'(UNIT - 1)));
          if ($urandom_range(0, 1) == 1) d[a] = -d[a];
        end
        pos_m[c][k]  = mk(p[0], p[1], p[2]);
        disp_m[c][k] = mk(d[0], d[1], d[2]);
      end
    end
  endtask

  // Cache model: one-cycle read latency from the selected cell's cache.
  always @(posedge clk) begin
    cell_id_t cid;
    int idx;
    if (out_rden) begin
      cid = unpack_cell(out_rd_cell);
      idx = ((int'(cid.x) - 1) * 3 + (int'(cid.y) - 1)) * 2 + (int'(cid.z) - 1);
      if (idx >= 0 && idx < NCELLS) begin
        if (out_read_address == 8'd0) begin
          in_pos_data  <= 96'(cnt_m[idx]);
          in_disp_data <= '0;
        end else if (int'(out_read_address) <= MAXP) begin
          in_pos_data  <= pos_m[idx][int'(out_read_address) - 1];
          in_disp_data <= disp_m[idx][int'(out_read_address) - 1];
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  // Monitor: scoreboard pops, latency, enable coverage and done spacing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (out_rden && out_read_address != 8'd0) lat_q.push_back(cyc + 2);
      if (out_rden && out_read_address == 8'd0) visits++;
      if (out_data_valid) begin
        check("en_during_valid", 128'(out_motion_update_enable), 128'(1));
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 128'(out_data), 128'(0) - 1);
        end else begin
          e = exp_q.pop_front();
          check("data", 128'(out_data), 128'(e.data));
          check("dst_cell", 128'(out_data_dst_cell), 128'(e.dst));
        end
        if (lat_q.size() == 0) check("valid_latency", 128'(cyc), 128'(0) - 1);
        else check("valid_latency", 128'(cyc), 128'(lat_q.pop_front()));
      end else begin
        check("idle_zero", {20'd0, out_data_dst_cell, out_data}, 128'(0));
      end
      if (prev_en && !out_motion_update_enable) fall_cyc = cyc;
      if (out_done) begin
        done_cnt++;
        check("done_gap", 128'(cyc - fall_cyc), 128'(3));
      end
      prev_en = out_motion_update_enable;
    end
  end

  task automatic run_test(input bit extra_start);
    int cycles;
    bit pulsed;
    build_expected();
    lat_q.delete();
    visits = 0;
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("en_rise", 128'(out_motion_update_enable), 128'(1));
    check("no_read_yet", 128'(out_rden), 128'(0));
    @(posedge clk); #1;
    check("count_read", 128'({out_rden, out_read_address}), 128'({1'b1, 8'd0}));
    cycles = 0;
    pulsed = 1'b0;
    while (done_cnt == 0 && cycles < 4000) begin
      @(posedge clk); #1;
      cycles++;
      if (extra_start && !pulsed && out_rden && out_read_address != 8'd0) begin
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        pulsed = 1'b1;
      end
    end
    repeat (8) @(posedge clk);
    #1;
    check("done_pulses", 128'(done_cnt), 128'(1));
    check("sb_empty", 128'(exp_q.size()), 128'(0));
    check("cell_visits", 128'(visits), 128'(NCELLS));
    check("en_low_after", 128'(out_motion_update_enable), 128'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_cell"}, 128'(out_rd_cell), 128'(0));
    check({tag, "_addr_rden"}, 128'({out_read_address, out_rden}), 128'(0));
    check({tag, "_en"}, 128'(out_motion_update_enable), 128'(0));
    check({tag, "_data"}, 128'(out_data), 128'(0));
    check({tag, "_dst_vld_done"}, 128'({out_data_dst_cell, out_data_valid, out_done}), 128'(0));
  endtask

  initial begin
    int cycles;
    rst = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Every cache empty: no broadcast, all 18 cells still visited.
    run_test(1'b0);

    // Directed: plain add in cell (1,1,1), plus x and z wraps both ways.
    clear_mem();
    cnt_m[0] = 2;
    pos_m[0][0]  = mk(UNIT / 2, UNIT / 2, UNIT / 2);
    disp_m[0][0] = mk(UNIT / 4, 0, 0);
    pos_m[0][1]  = mk(29 * UNIT / 10, UNIT / 2, 19 * UNIT / 10);
    disp_m[0][1] = mk(UNIT / 5, 0, UNIT / 5);
    cnt_m[1] = 1;
    pos_m[1][0]  = mk(UNIT / 10, UNIT / 10, UNIT / 10);
    disp_m[1][0] = mk(-(UNIT / 5), -(UNIT / 5), -(UNIT / 5));
    cnt_m[17] = 1;
    pos_m[17][0]  = mk(3 * UNIT - 1, 3 * UNIT - 1, 2 * UNIT - 1);
    disp_m[17][0] = mk(1, 0, -1);
    run_test(1'b0);

    // Random caches.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_test(1'b0);
    end

    // Reset in the middle of streaming, then a clean restart.
    fill_random();
    cnt_m[0] = 3;
    for (int k = 0; k < 3; k++) begin
      pos_m[0][k]  = mk(UNIT, UNIT, UNIT);
      disp_m[0][k] = mk(k, k, k);
    end
    build_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cycles = 0;
    while (!(out_rden && out_read_address != 8'd0) && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("reached_stream", 128'(out_rden && out_read_address != 8'd0), 128'(1));
    #2 rst = 1'b1;
    #1 check_all_zero("abort");
    exp_q.delete();
    lat_q.delete();
    @(posedge clk); #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_test(1'b0);

    // Start pulsed while streaming must be ignored.
    fill_random();
    cnt_m[2] = 4;
    run_test(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
